// File: rtl/volume_ramp_ctrl.sv
// Volume control that applies a left shift to a streaming sample, saturating on overflow.
// The applied shift ramps one step toward the button-set target every RAMP_DIV samples.
module volume_ramp_ctrl #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned RAMP_DIV    = 256,
  parameter int unsigned RESET_LEVEL = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_up,
  input  logic              btn_down,
  input  logic              mute,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2:0]        target_level,
  output logic [2:0]        cur_shift,
  output logic              ramping
);

  typedef enum logic [1:0] {StIdle, StRampUp, StRampDown} state_e;

  localparam int unsigned WideW      = DATA_W + 7;
  localparam logic [15:0] DivLast    = 16'(RAMP_DIV - 1);
  localparam logic [2:0]  ResetShift = 3'(RESET_LEVEL);

  localparam logic signed [WideW-1:0] MaxVal = {{8{1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [WideW-1:0] MinVal = {{8{1'b1}}, {(DATA_W-1){1'b0}}};

  state_e            stateQ, stateD;
  logic [2:0]        targetQ, targetD;
  logic [2:0]        curQ, curD;
  logic [15:0]       cntQ, cntD;
  logic [DATA_W-1:0] outDataQ, outDataD;
  logic              outValidQ, outValidD;

  logic                    inXfer, outXfer, rampActive, cntHit, doStep;
  logic signed [WideW-1:0] wideIn, shifted;
  logic [DATA_W-1:0]       gained;

  assign in_ready     = !outValidQ || out_ready;
  assign inXfer       = in_valid && in_ready;
  assign outXfer      = outValidQ && out_ready;
  assign out_data     = outDataQ;
  assign out_valid    = outValidQ;
  assign target_level = targetQ;
  assign cur_shift    = curQ;
  assign ramping      = (stateQ != StIdle);

  // Seven guard bits hold the largest shift exactly, so saturation is a plain compare.
  always_comb begin
    wideIn  = {{7{in_data[DATA_W-1]}}, in_data};
    shifted = wideIn <<< curQ;
    if (shifted > MaxVal) begin
      gained = {1'b0, {(DATA_W-1){1'b1}}};
    end else if (shifted < MinVal) begin
      gained = {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      gained = shifted[DATA_W-1:0];
    end
  end

  always_comb begin
    outDataD  = outDataQ;
    outValidD = outValidQ;
    if (inXfer) begin
      outDataD  = mute ? '0 : gained;
      outValidD = 1'b1;
    end else if (outXfer) begin
      outValidD = 1'b0;
    end
  end

  always_comb begin
    stateD = StIdle;
    if (curQ < targetQ) begin
      stateD = StRampUp;
    end else if (curQ > targetQ) begin
      stateD = StRampDown;
    end
  end

  always_comb begin
    rampActive = (stateQ != StIdle);
    cntHit     = (cntQ == DivLast);
    doStep     = rampActive && inXfer && cntHit && (curQ != targetQ);

    curD = curQ;
    if (doStep) begin
      curD = (curQ < targetQ) ? curQ + 3'd1 : curQ - 3'd1;
    end

    cntD = cntQ;
    if (stateD != stateQ) begin
      cntD = '0;
    end else if (rampActive && inXfer) begin
      cntD = cntHit ? 16'd0 : cntQ + 16'd1;
    end

    targetD = targetQ;
    if (btn_up && !btn_down && targetQ != 3'd7) begin
      targetD = targetQ + 3'd1;
    end else if (btn_down && !btn_up && targetQ != 3'd0) begin
      targetD = targetQ - 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ    <= StIdle;
      targetQ   <= ResetShift;
      curQ      <= ResetShift;
      cntQ      <= '0;
      outDataQ  <= '0;
      outValidQ <= 1'b0;
    end else begin
      stateQ    <= stateD;
      targetQ   <= targetD;
      curQ      <= curD;
      cntQ      <= cntD;
      outDataQ  <= outDataD;
      outValidQ <= outValidD;
    end
  end

endmodule

// File: tb/tb_volume_ramp_ctrl.sv
// Randomized and directed bench for volume_ramp_ctrl against a cycle-level arithmetic model.
module tb_volume_ramp_ctrl;

  localparam int DW  = 16;
  localparam int DIV = 4;
  localparam int RL  = 0;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          btn_up = 1'b0, btn_down = 1'b0, mute = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [2:0]    target_level, cur_shift;
  logic          ramping;

  always #5 clk = ~clk;

  volume_ramp_ctrl #(
    .DATA_W     (DW),
    .RAMP_DIV   (DIV),
    .RESET_LEVEL(RL)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_up      (btn_up),
    .btn_down    (btn_down),
    .mute        (mute),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .target_level(target_level),
    .cur_shift   (cur_shift),
    .ramping     (ramping)
  );

  int nChecks = 0;
  int nErrors = 0;

  // Model: dir is the ramp direction (-1/0/+1) seen one cycle after the shift/target compare.
  int            mTarget = RL, mCur = RL, mDir = 0, mCnt = 0;
  bit            mOv = 1'b0;
  logic [DW-1:0] mOd = '0;

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nErrors++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] gainOf(input logic [DW-1:0] d, input int sh, input bit mu);
    int v;
    if (mu) return '0;
    v = int'($signed(d)) * (1 << sh);
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
    return v[DW-1:0];
  endfunction

  task automatic tick();
    bit inX, outX;
    int nd;
    #1;
    if (!rst) checkEq("in_ready", {31'd0, in_ready}, {31'd0, (!mOv || out_ready)});
    inX  = in_valid && (!mOv || out_ready);
    outX = mOv && out_ready;
    @(posedge clk);
    if (rst) begin
      mTarget = RL; mCur = RL; mDir = 0; mCnt = 0; mOv = 1'b0; mOd = '0;
    end else begin
      if (inX) begin
        mOd = gainOf(in_data, mCur, mute);
        mOv = 1'b1;
      end else if (outX) begin
        mOv = 1'b0;
      end
      nd = (mTarget > mCur) ? 1 : ((mTarget < mCur) ? -1 : 0);
      if (mDir != 0 && inX && mCnt == DIV - 1 && nd != 0) mCur += nd;
      if (nd != mDir) mCnt = 0;
      else if (mDir != 0 && inX) mCnt = (mCnt == DIV - 1) ? 0 : mCnt + 1;
      if (btn_up && !btn_down && mTarget < 7) mTarget++;
      else if (btn_down && !btn_up && mTarget > 0) mTarget--;
      mDir = nd;
    end
    #1;
    checkEq("out_valid", {31'd0, out_valid}, {31'd0, mOv});
    checkEq("out_data", {16'd0, out_data}, {16'd0, mOd});
    checkEq("target_level", {29'd0, target_level}, 32'(mTarget));
    checkEq("cur_shift", {29'd0, cur_shift}, 32'(mCur));
    checkEq("ramping", {31'd0, ramping}, {31'd0, (mDir != 0)});
  endtask

  task automatic drive(input bit r, input bit u, input bit d, input bit m, input bit v,
                       input logic [DW-1:0] dat, input bit ordy);
    rst = r; btn_up = u; btn_down = d; mute = m; in_valid = v; in_data = dat; out_ready = ordy;
    tick();
  endtask

  logic [DW-1:0] held;
  logic [2:0]    tgtSave, curSave;

  initial begin
    // Reset and unity-gain passthrough
    drive(1, 0, 0, 0, 0, '0, 1);
    drive(1, 0, 0, 0, 0, '0, 1);
    checkEq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkEq("rst_cur", {29'd0, cur_shift}, 32'(RL));
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, 0, 0, 1, 16'h0100, 1);
      checkEq("pass_data", {16'd0, out_data}, 32'h0100);
    end

    // One step up at RAMP_DIV=4
    drive(0, 1, 0, 0, 0, '0, 1);
    for (int i = 0; i < 10; i++) drive(0, 0, 0, 0, 1, 16'h0100, 1);
    checkEq("step_data", {16'd0, out_data}, 32'h0200);
    checkEq("step_cur", {29'd0, cur_shift}, 32'd1);
    checkEq("step_ramping", {31'd0, ramping}, 32'd0);

    // Climb to the top and check saturation
    for (int i = 0; i < 9; i++) drive(0, 1, 0, 0, 0, '0, 1);
    checkEq("tgt_sat", {29'd0, target_level}, 32'd7);
    for (int i = 0; i < 40; i++) drive(0, 0, 0, 0, 1, DW'($urandom), 1);
    checkEq("cur_top", {29'd0, cur_shift}, 32'd7);
    drive(0, 0, 0, 0, 1, 16'h1000, 1);
    checkEq("sat_pos", {16'd0, out_data}, 32'h7FFF);
    drive(0, 0, 0, 0, 1, 16'hF000, 1);
    checkEq("sat_neg", {16'd0, out_data}, 32'h8000);

    // Back-pressure mid ramp-down
    drive(0, 0, 1, 0, 1, 16'h0011, 1);
    drive(0, 0, 0, 0, 1, 16'h0022, 1);
    drive(0, 0, 0, 0, 1, 16'h0033, 1);
    held = out_data;
    curSave = cur_shift;
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 0, 0, 1, DW'($urandom), 0);
      checkEq("bp_hold", {16'd0, out_data}, {16'd0, held});
      checkEq("bp_cur", {29'd0, cur_shift}, {29'd0, curSave});
    end
    for (int i = 0; i < 8; i++) drive(0, 0, 0, 0, 1, DW'($urandom), 1);

    // Simultaneous buttons, then mute during a ramp
    tgtSave = target_level;
    drive(0, 1, 1, 0, 1, 16'h0040, 1);
    checkEq("both_btn", {29'd0, target_level}, {29'd0, tgtSave});
    drive(0, 0, 1, 1, 1, 16'h0040, 1);
    drive(0, 0, 1, 1, 1, 16'h0040, 1);
    curSave = cur_shift;
    for (int i = 0; i < 12; i++) begin
      drive(0, 0, 0, 1, 1, DW'($urandom), 1);
      checkEq("mute_zero", {16'd0, out_data}, 32'd0);
    end
    checkEq("mute_ramped", {31'd0, (cur_shift != curSave)}, 32'd1);

    // Reset in RAMP_UP with two samples counted
    drive(1, 0, 0, 0, 0, '0, 1);
    drive(0, 1, 0, 0, 0, '0, 1);
    drive(0, 0, 0, 0, 0, '0, 1);
    drive(0, 0, 0, 0, 1, 16'h0100, 0);
    drive(0, 0, 0, 0, 1, 16'h0100, 1);
    drive(1, 1, 0, 0, 1, 16'h0100, 1);
    checkEq("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    checkEq("mid_rst_ramping", {31'd0, ramping}, 32'd0);
    checkEq("mid_rst_tgt", {29'd0, target_level}, 32'(RL));

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(99) == 0), ($urandom_range(9) == 0), ($urandom_range(9) == 0),
            ($urandom_range(7) == 0), ($urandom_range(3) != 0), DW'($urandom),
            ($urandom_range(2) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule

// File: doc/volume_ramp_ctrl.md
VOLUME_RAMP_CTRL -- requirements
Module: volume_ramp_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16: sample width, signed two's complement.
REQ-002 The block SHALL have parameter RAMP_DIV, default 256: accepted samples per one-step gain change, range 2..65535.
REQ-003 The block SHALL have parameter RESET_LEVEL, default 0: target and current shift after reset, range 0..7.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic SHALL be on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port btn_up, input, 1 bit: single-cycle pulse that requests target +1.
REQ-007 The block SHALL have port btn_down, input, 1 bit: single-cycle pulse that requests target -1.
REQ-008 The block SHALL have port mute, input, 1 bit: level-sensitive output mute.
REQ-009 The block SHALL have port in_data, input, DATA_W bits: input sample.
REQ-010 The block SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-011 The block SHALL have port in_ready, output, 1 bit: the block accepts in_data this cycle.
REQ-012 The block SHALL have port out_data, output, DATA_W bits: gained sample.
REQ-013 The block SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-014 The block SHALL have port out_ready, input, 1 bit: the downstream block accepts out_data.
REQ-015 The block SHALL have port target_level, output, 3 bits: requested left-shift amount.
REQ-016 The block SHALL have port cur_shift, output, 3 bits: shift currently applied.
REQ-017 The block SHALL have port ramping, output, 1 bit: high whenever state is not IDLE.

Function
REQ-018 A transfer SHALL occur on an input port when in_valid and in_ready are both high, and on the output port when out_valid and out_ready are both high.
REQ-019 in_ready SHALL be combinational and equal to !out_valid || out_ready.
REQ-020 On each input transfer, out_data SHALL register the gained sample in the same edge and out_valid SHALL go high, for a latency of 1 cycle.
REQ-021 out_valid SHALL clear after an output transfer that has no simultaneous input transfer.
REQ-022 out_data and out_valid SHALL hold stable while out_valid=1 and out_ready=0.
REQ-023 The gain SHALL equal in_data arithmetically shifted left by cur_shift, as sampled at the transfer edge.
REQ-024 A gained value above 2^(DATA_W-1)-1 SHALL saturate to 0x7FFF, and a gained value below -2^(DATA_W-1) SHALL saturate to 0x8000 (values given for DATA_W=16).
REQ-025 When mute=1 at the transfer edge, out_data SHALL be 0; the handshake and the ramp SHALL continue unaffected.
REQ-026 btn_up SHALL increment target_level and SHALL saturate at 7.
REQ-027 btn_down SHALL decrement target_level and SHALL saturate at 0.
REQ-028 When btn_up and btn_down are high in the same cycle, target_level SHALL NOT change.
REQ-029 The FSM SHALL have states IDLE, RAMP_UP and RAMP_DOWN, and its next state SHALL be evaluated every cycle from the registered cur_shift and target_level.
REQ-030 The FSM SHALL go to IDLE when cur_shift equals target_level, to RAMP_UP when cur_shift is less than target_level, and to RAMP_DOWN when cur_shift is greater than target_level.
REQ-031 A 16-bit sample counter SHALL increment on each input transfer while in RAMP_UP or RAMP_DOWN.
REQ-032 When the counter equals RAMP_DIV-1 and an input transfer occurs, cur_shift SHALL step by ±1 toward target_level and the counter SHALL clear.
REQ-033 The counter SHALL clear on any state change, including a direction reversal mid-ramp.
REQ-034 A new cur_shift SHALL first apply to the transfer that follows the stepping transfer.
REQ-035 No ramp progress SHALL occur while there are no input transfers, including under sustained back-pressure.

Reset
REQ-036 While rst=1 at the rising edge, the block SHALL set state=IDLE, target_level=RESET_LEVEL, cur_shift=RESET_LEVEL, counter=0, out_valid=0 and out_data=0.
REQ-037 Reset SHALL take priority over buttons and transfers in the same cycle.
REQ-038 A reset asserted mid-ramp or with out_valid=1 SHALL discard the pending sample and the remaining ramp.
REQ-039 in_ready SHALL be 1 in the first cycle after reset is released.

Verification
REQ-040 Bench: reset, out_ready=1, stream in_data=0x0100 -> out_data=0x0100 one cycle after each transfer, cur_shift=0, ramping=0.
REQ-041 Bench: RAMP_DIV=4, one btn_up pulse, continuous stream -> cur_shift becomes 1 on the 4th transfer; the 5th sample 0x0100 yields 0x0200, and ramping returns to 0.
REQ-042 Bench: 9 btn_up pulses -> target_level=7; in_data=0x1000 at cur_shift=7 -> out_data=0x7FFF; in_data=0xF000 -> out_data=0x8000.
REQ-043 Bench: out_ready=0 for 10 cycles with out_valid=1 -> out_data stable, in_ready=0, counter unchanged; on release, one sample transfers per cycle.
REQ-044 Bench: btn_up and btn_down in the same cycle -> target_level unchanged; mute=1 -> out_data=0 while cur_shift still ramps.
REQ-045 Bench: rst during RAMP_UP with counter=2 -> next cycle state=IDLE, cur_shift=RESET_LEVEL, out_valid=0, counter=0.
